// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Purpose  : Fetch PC owner, imem request issue, redirect flush and
//            wrong-path response squashing. Optional FETCH_REDIRECT_CNT_EN
//            adds a saturating redirect counter on redirect_cnt_o.
// Revision : 1.0  initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_sel_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o
`ifdef FETCH_REDIRECT_CNT_EN
    ,
    output logic [CNT_W-1:0] redirect_cnt_o
`endif
);

    localparam logic [1:0] MAX_O     = 2'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_SLOT = 2'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  squash_q, squash_d;
    logic        hold_q, hold_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] fifo_q [4];
    logic [31:0] fifo_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        accept;
    logic        rsp_take;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = out_q;
        squash_d    = squash_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        req_valid   = 1'b0;
        // A held request keeps its original address even across a redirect.
        req_addr    = hold_q ? hold_addr_q : pc_q;

        unique case (state_q)
            ST_RUN:   req_valid = hold_q || (!stall_i && (out_q < MAX_O));
            ST_DRAIN: req_valid = hold_q;
            default:  req_valid = 1'b0;
        endcase

        accept      = req_valid && imem_req_ready_i;
        rsp_take    = imem_rsp_valid_i && (out_q != 2'd0);
        hold_d      = req_valid && !imem_req_ready_i;
        hold_addr_d = req_addr;

        if (accept && !rsp_take) begin
            out_d = out_q + 2'd1;
        end else if (!accept && rsp_take) begin
            out_d = out_q - 2'd1;
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = req_addr;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end
        if (rsp_take) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
            if (squash_q != 2'd0) begin
                squash_d = squash_q - 2'd1;
            end
        end

        unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (accept) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Everything still owed by memory, plus a stuck request, is wrong-path.
        if (pc_sel_i) begin
            pc_d     = {target_i[31:2], 2'b00};
            squash_d = out_d + {1'b0, hold_d};
            state_d  = hold_d ? ST_DRAIN : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            out_q       <= 2'd0;
            squash_q    <= 2'd0;
            hold_q      <= 1'b0;
            hold_addr_q <= 32'd0;
            fifo_q      <= '{default: 32'd0};
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            squash_q    <= squash_d;
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign imem_req_valid_o = req_valid && !reset;
    assign imem_req_addr_o  = req_addr;
    assign if_valid_o       = rsp_take && (squash_q == 2'd0) && !pc_sel_i && !reset;
    assign if_instr_o       = imem_rsp_data_i;
    assign if_pc_o          = fifo_q[rd_ptr_q];
    assign flush_if_id_o    = pc_sel_i && !reset;
    assign flush_id_ex_o    = pc_sel_i && !reset;

`ifdef FETCH_REDIRECT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pc_sel_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign redirect_cnt_o = cnt_q;

    logic unused_ok;
    assign unused_ok = ^target_i[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{target_i[1:0], (CNT_W == 0)};
`endif

`ifndef SYNTHESIS
    rsp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid_i && (out_q == 2'd0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Purpose  : Directed and random checks of fetch_redirect_ctrl against an
//            in-order request/response model that tags wrong-path fetches.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int MAXO = 2;
    localparam int CW   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_sel_i = 1'b0;
    logic [31:0] target_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b0;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = 32'd0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
`ifdef FETCH_REDIRECT_CNT_EN
    logic [CW-1:0] redirect_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (MAXO),
        .CNT_W           (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_sel_i         (pc_sel_i),
        .target_i         (target_i),
        .stall_i          (stall_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .if_valid_o       (if_valid_o),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .flush_if_id_o    (flush_if_id_o),
        .flush_id_ex_o    (flush_id_ex_o)
`ifdef FETCH_REDIRECT_CNT_EN
        ,
        .redirect_cnt_o   (redirect_cnt_o)
`endif
    );

    // In-flight fetches in issue order; 'wrong' marks fetches made obsolete by a redirect.
    typedef struct packed {
        logic [31:0] addr;
        logic        wrong;
    } fetch_t;

    fetch_t      inflight[$];
    logic [31:0] m_pc, m_held_addr;
    bit          m_run, m_held, m_drain;
    int          n_checks = 0;
    int          n_fail   = 0;

    bit          e_valid, e_rsp, e_ifv;
    logic [31:0] e_addr, e_pc, e_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_pc    = 32'h0000_0000;
        m_run   = 0;
        m_held  = 0;
        m_drain = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; stall_i = 1'b0; pc_sel_i = 1'b0; target_i = 32'd0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drives one cycle, computes this cycle's expectations, then advances the model past the edge.
    task automatic drive(input bit stall, input bit sel, input logic [31:0] tgt,
                         input bit rdy, input bit rsp_en);
        bit     acc;
        fetch_t f;
        @(negedge clk);
        stall_i = stall; pc_sel_i = sel; target_i = tgt; imem_req_ready_i = rdy;
        e_rsp            = rsp_en && (inflight.size() > 0);
        e_pc             = e_rsp ? inflight[0].addr : 32'd0;
        e_instr          = mem_word(e_pc);
        e_ifv            = e_rsp && !inflight[0].wrong && !sel;
        imem_rsp_valid_i = e_rsp;
        imem_rsp_data_i  = e_rsp ? e_instr : $urandom;
        e_valid = m_run && (m_held || (!m_drain && !stall && (inflight.size() < MAXO)));
        e_addr  = m_held ? m_held_addr : m_pc;
        #1;
        acc = e_valid && rdy;
        if (e_rsp) void'(inflight.pop_front());
        if (acc) begin
            f.addr  = e_addr;
            f.wrong = sel || m_drain;
            inflight.push_back(f);
        end
        if (sel) begin
            for (int i = 0; i < inflight.size(); i++) begin
                f = inflight[i];
                f.wrong = 1'b1;
                inflight[i] = f;
            end
            m_pc    = {tgt[31:2], 2'b00};
            m_drain = e_valid && !rdy;
        end else begin
            if (acc && !m_drain) m_pc = m_pc + 32'd4;
            if (acc) m_drain = 0;
        end
        m_held      = e_valid && !rdy;
        m_held_addr = e_addr;
        m_run       = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; pc_sel_i = 1'b1; target_i = 32'h1234; stall_i = 1'b0;
        imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid_o); end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", if_valid_o); end
        n_checks++;
        if (flush_if_id_o !== 1'b0 || flush_id_ex_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flush: got %b%b expected 00", flush_if_id_o, flush_id_ex_o);
        end
`ifdef FETCH_REDIRECT_CNT_EN
        n_checks++;
        if (redirect_cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", redirect_cnt_o); end
`endif
        pc_sel_i = 1'b0;
        reset    = 1'b0;
        model_reset();
        drive(0, 0, 32'd0, 1, 0);
        n_checks++;
        if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_req_valid: got %b expected 0", imem_req_valid_o); end
        drive(0, 0, 32'd0, 1, 0);
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid_o, imem_req_addr_o);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        drive(0, 0, 32'd0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'd0, 1, 1);
            n_checks++;
            if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'(4 * i)) begin
                n_fail++; $display("FAIL seq_req %0d: got v=%b a=%h expected v=1 a=%h", i, imem_req_valid_o, imem_req_addr_o, 32'(4 * i));
            end
            if (i > 0) begin
                n_checks++;
                if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * (i - 1)) || if_instr_o !== mem_word(32'(4 * (i - 1)))) begin
                    n_fail++; $display("FAIL seq_if %0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", i, if_valid_o, if_pc_o, if_instr_o,
                                       32'(4 * (i - 1)), mem_word(32'(4 * (i - 1))));
                end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        repeat (3) drive(0, 0, 32'd0, 1, 1);
        drive(0, 0, 32'd0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive(1, 0, 32'd0, (i == 3), 1);
            n_checks++;
            if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8) begin
                n_fail++; $display("FAIL stall_hold %0d: got v=%b a=%h expected v=1 a=00000008", i, imem_req_valid_o, imem_req_addr_o);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 32'd0, 1, 1);
            n_checks++;
            if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_block %0d: got %b expected 0", i, imem_req_valid_o); end
            n_checks++;
            if (if_valid_o !== e_ifv) begin n_fail++; $display("FAIL stall_if %0d: got %b expected %b", i, if_valid_o, e_ifv); end
        end
    endtask

    task automatic test_redirect_inflight();
        apply_reset();
        drive(0, 1, 32'h10, 1, 0);
        n_checks++;
        if (flush_if_id_o !== 1'b1 || flush_id_ex_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_redirect: got fl=%b%b v=%b expected fl=11 v=0", flush_if_id_o, flush_id_ex_o, imem_req_valid_o);
        end
        drive(0, 0, 32'd0, 1, 0);
        drive(0, 0, 32'd0, 1, 0);
        n_checks++;
        if (imem_req_addr_o !== 32'h14) begin n_fail++; $display("FAIL rdi_second_addr: got %h expected 00000014", imem_req_addr_o); end
        drive(0, 1, 32'h100, 1, 0);
        n_checks++;
        if (flush_if_id_o !== 1'b1 || flush_id_ex_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rdi_flush: got fl=%b%b v=%b expected fl=11 v=0", flush_if_id_o, flush_id_ex_o, imem_req_valid_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 32'd0, 0, 1);
            n_checks++;
            if (if_valid_o !== 1'b0 || flush_if_id_o !== 1'b0) begin
                n_fail++; $display("FAIL rdi_squash %0d: got v=%b fl=%b expected v=0 fl=0", i, if_valid_o, flush_if_id_o);
            end
        end
        drive(0, 0, 32'd0, 1, 1);
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h100) begin
            n_fail++; $display("FAIL rdi_new_req: got v=%b a=%h expected v=1 a=00000100", imem_req_valid_o, imem_req_addr_o);
        end
        drive(0, 0, 32'd0, 0, 1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_instr_o !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL rdi_new_if: got v=%b pc=%h d=%h expected v=1 pc=00000100 d=%h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_pending();
        apply_reset();
        drive(0, 1, 32'h20, 0, 0);
        drive(0, 0, 32'd0, 0, 0);
        drive(0, 1, 32'h203, 0, 0);
        drive(0, 0, 32'd0, 0, 0);
        drive(1, 0, 32'd0, 1, 0);
        n_checks++;
        if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h20) begin
            n_fail++; $display("FAIL pend_old_addr: got v=%b a=%h expected v=1 a=00000020", imem_req_valid_o, imem_req_addr_o);
        end
        drive(0, 0, 32'd0, 1, 1);
        n_checks++;
        if (imem_req_addr_o !== 32'h200 || if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL pend_new_addr: got a=%h ifv=%b expected a=00000200 ifv=0", imem_req_addr_o, if_valid_o);
        end
        drive(0, 0, 32'd0, 1, 1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h200) begin
            n_fail++; $display("FAIL pend_new_if: got v=%b pc=%h expected v=1 pc=00000200", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] first_pc;
        bit          seen;
        apply_reset();
        repeat (3) drive(0, 0, 32'd0, 1, 1);
        drive(0, 1, 32'h40, 1, 1);
        drive(0, 1, 32'h80, 1, 1);
        seen = 0;
        first_pc = 32'd0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 32'd0, 1, 1);
            if (if_valid_o === 1'b1 && !seen) begin
                seen = 1;
                first_pc = if_pc_o;
            end
        end
        n_checks++;
        if (!seen || first_pc !== 32'h80) begin
            n_fail++; $display("FAIL b2b_first_pc: got seen=%b pc=%h expected seen=1 pc=00000080", seen, first_pc);
        end
    endtask

    task automatic test_random();
        bit sel;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(199) == 0) apply_reset();
            sel = ($urandom_range(7) == 0);
            drive(($urandom_range(3) == 0), sel, $urandom, $urandom_range(1), $urandom_range(1));
            n_checks++;
            if (imem_req_valid_o !== e_valid) begin
                n_fail++; $display("FAIL rnd_req_valid c%0d: got %b expected %b", cyc, imem_req_valid_o, e_valid);
            end
            if (e_valid) begin
                n_checks++;
                if (imem_req_addr_o !== e_addr) begin
                    n_fail++; $display("FAIL rnd_req_addr c%0d: got %h expected %h", cyc, imem_req_addr_o, e_addr);
                end
            end
            n_checks++;
            if (if_valid_o !== e_ifv) begin
                n_fail++; $display("FAIL rnd_if_valid c%0d: got %b expected %b", cyc, if_valid_o, e_ifv);
            end
            if (e_ifv) begin
                n_checks++;
                if (if_pc_o !== e_pc || if_instr_o !== e_instr) begin
                    n_fail++; $display("FAIL rnd_if_data c%0d: got pc=%h d=%h expected pc=%h d=%h", cyc, if_pc_o, if_instr_o, e_pc, e_instr);
                end
            end
            n_checks++;
            if (flush_if_id_o !== sel || flush_id_ex_o !== sel) begin
                n_fail++; $display("FAIL rnd_flush c%0d: got %b%b expected %b%b", cyc, flush_if_id_o, flush_id_ex_o, sel, sel);
            end
        end
    endtask

`ifdef FETCH_REDIRECT_CNT_EN
    task automatic test_redirect_counter();
        apply_reset();
        repeat (3) drive(0, 1, $urandom, 1, 1);
        drive(0, 0, 32'd0, 1, 1);
        n_checks++;
        if (redirect_cnt_o !== 4'h3) begin n_fail++; $display("FAIL cnt_three: got %h expected 3", redirect_cnt_o); end
        repeat (14) drive(0, 1, $urandom, 1, 1);
        drive(0, 0, 32'd0, 1, 1);
        n_checks++;
        if (redirect_cnt_o !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected f", redirect_cnt_o); end
        apply_reset();
        n_checks++;
        if (redirect_cnt_o !== 4'h0) begin n_fail++; $display("FAIL cnt_reset: got %h expected 0", redirect_cnt_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_inflight();
        test_redirect_pending();
        test_back_to_back();
        test_random();
`ifdef FETCH_REDIRECT_CNT_EN
        test_redirect_counter();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
